// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared sizing and index helpers for the systolic array result path
// Purpose: result width, PE index mapping and index width helpers.
// Ports: none (package).
package systolic_pkg;

  // Each PE accumulator result is twice the operand width.
  function automatic int result_width(input int dbits);
    return 2 * dbits;
  endfunction

  // Column-major PE numbering: p = col*ROWS + row.
  function automatic int pe_index(input int row, input int col, input int rows);
    return col * rows + row;
  endfunction

  // Index width, never narrower than one bit.
  function automatic int idx_width(input int npe);
    return (npe <= 1) ? 1 : $clog2(npe);
  endfunction

endpackage

// File: rtl/systolic_result_drain_if.sv
// rtl/systolic_result_drain_if.sv - drained result stream (data, PE index, valid/ready)
// Purpose: groups the output beat and its handshake.
// Signals: o_DATA result, o_INDEX PE index, o_VALID beat valid, i_READY downstream accept.
// Modports: master = drain side (drives beat), slave = consumer side (drives ready).
interface systolic_result_drain_if #(
  parameter int DBITS = 8,
  parameter int ROWS  = 2,
  parameter int COLS  = 2
);
  import systolic_pkg::*;

  localparam int RW   = result_width(DBITS);
  localparam int NPE  = ROWS * COLS;
  localparam int IDXW = idx_width(NPE);

  logic [RW-1:0]   o_DATA;
  logic [IDXW-1:0] o_INDEX;
  logic            o_VALID;
  logic            i_READY;

  modport master (output o_DATA, output o_INDEX, output o_VALID, input i_READY);
  modport slave  (input o_DATA, input o_INDEX, input o_VALID, output i_READY);
endinterface

// File: rtl/systolic_rr_pick.sv
// rtl/systolic_rr_pick.sv - combinational round-robin picker over a full-slot vector
// Purpose: first set bit of full at or after ptr, wrapping.
// Ports: full (NPE) slot flags, ptr (IDXW) start index, found any slot full, sel picked index.
module systolic_rr_pick #(
  parameter int NPE  = 4,
  parameter int IDXW = 2
) (
  input  logic [NPE-1:0]  full,
  input  logic [IDXW-1:0] ptr,
  output logic            found,
  output logic [IDXW-1:0] sel
);

  int j;

  // Scan from the far end back toward ptr so the candidate nearest ptr wins last.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    j     = 0;
    for (int k = NPE - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NPE;
      if (full[j]) begin
        found = 1'b1;
        sel   = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/systolic_result_drain.sv
// rtl/systolic_result_drain.sv - per-PE result slots drained round-robin onto one stream
// Purpose: capture per-PE results, hold one per slot, drain one beat per cycle tagged with PE index.
// Ports: i_CLK clock, i_RST sync active-high reset, i_DATA packed PE results, i_VALID per-PE strobes,
//        drain (master) output stream, o_BUSY slots/output occupied, o_OVERRUN sticky lost result,
//        i_CLR_OVR clears o_OVERRUN.
// Option: SYSTOLIC_DRAIN_OVR_EN enables overrun detection (new result dropped, held value kept);
//         otherwise a result on a full slot overwrites silently and o_OVERRUN is 0.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int DBITS = 8,
  parameter int ROWS  = 2,
  parameter int COLS  = 2,
  localparam int RW   = result_width(DBITS),
  localparam int NPE  = ROWS * COLS,
  localparam int IDXW = idx_width(NPE)
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic [NPE*RW-1:0]     i_DATA,
  input  logic [NPE-1:0]        i_VALID,
  systolic_result_drain_if.master drain,
  output logic                  o_BUSY,
  output logic                  o_OVERRUN,
  input  logic                  i_CLR_OVR
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t          state, next_state;
  logic [NPE-1:0]  full;
  logic [RW-1:0]   slot [NPE];
  logic [IDXW-1:0] ptr;
  logic            found;
  logic [IDXW-1:0] sel;
  logic            load;
  logic [NPE-1:0]  move_vec;
  logic [NPE-1:0]  cap;
  logic [RW-1:0]   out_data;
  logic [IDXW-1:0] out_index;

  systolic_rr_pick #(.NPE(NPE), .IDXW(IDXW)) u_pick (
    .full  (full),
    .ptr   (ptr),
    .found (found),
    .sel   (sel)
  );

  always_ff @(posedge i_CLK) begin
    if (i_RST) state <= S_EMPTY;
    else       state <= next_state;
  end

  // The output register refills whenever it is empty or its beat is taken this cycle.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      S_EMPTY: begin
        if (found) begin
          next_state = S_FULL;
          load       = 1'b1;
        end
      end
      S_FULL: begin
        if (drain.i_READY) begin
          if (found) load = 1'b1;
          else       next_state = S_EMPTY;
        end
      end
      default: next_state = S_EMPTY;
    endcase
  end

  always_comb begin
    move_vec = '0;
    if (load) move_vec[sel] = 1'b1;
  end

  // A slot that is moving this cycle can take a new result on the same edge.
`ifdef SYSTOLIC_DRAIN_OVR_EN
  assign cap = i_VALID & (~full | move_vec);
`else
  assign cap = i_VALID;
`endif

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      full      <= '0;
      ptr       <= '0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      full <= (full & ~move_vec) | cap;
      if (load) begin
        out_data  <= slot[sel];
        out_index <= sel;
        ptr       <= (sel == IDXW'(NPE - 1)) ? '0 : sel + 1'b1;
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    for (int p = 0; p < NPE; p++) begin
      if (cap[p]) slot[p] <= i_DATA[p*RW +: RW];
    end
  end

`ifdef SYSTOLIC_DRAIN_OVR_EN
  logic ovr_q;
  logic ovr_hit;
  assign ovr_hit = |(i_VALID & full & ~move_vec);

  // Set has priority over a simultaneous clear so no loss goes unreported.
  always_ff @(posedge i_CLK) begin
    if (i_RST)          ovr_q <= 1'b0;
    else if (ovr_hit)   ovr_q <= 1'b1;
    else if (i_CLR_OVR) ovr_q <= 1'b0;
  end
  assign o_OVERRUN = ovr_q;
`else
  logic unused_clr;
  assign unused_clr = i_CLR_OVR;
  assign o_OVERRUN  = 1'b0;
`endif

  assign drain.o_DATA  = out_data;
  assign drain.o_INDEX = out_index;
  assign drain.o_VALID = (state == S_FULL);
  assign o_BUSY        = (|full) | (state == S_FULL);

endmodule

// File: tb/tb_systolic_result_drain.sv
// tb/tb_systolic_result_drain.sv - self-checking bench for systolic_result_drain
module tb_systolic_result_drain;
  import systolic_pkg::*;

  localparam int NPE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] i_data;
  logic [3:0]  i_valid;
  logic        busy;
  logic        ovr;
  logic        clr;

  int checks = 0;
  int errors = 0;

  systolic_result_drain_if #(.DBITS(8), .ROWS(2), .COLS(2)) dif ();

  systolic_result_drain #(.DBITS(8), .ROWS(2), .COLS(2)) dut (
    .i_CLK     (clk),
    .i_RST     (rst),
    .i_DATA    (i_data),
    .i_VALID   (i_valid),
    .drain     (dif.master),
    .o_BUSY    (busy),
    .o_OVERRUN (ovr),
    .i_CLR_OVR (clr)
  );

  always #5 clk = ~clk;

`ifdef SYSTOLIC_DRAIN_OVR_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  // Reference model: slots as plain arrays, output as a single held beat.
  logic [15:0] m_slot [NPE];
  bit          m_full [NPE];
  bit          m_v;
  logic [15:0] m_d;
  int          m_i;
  int          m_ptr;
  bit          m_ovr;

  task automatic model_step(input logic r, input logic [3:0] vld, input logic [63:0] data,
                            input logic rdy, input logic c);
    int moved;
    bit set;
    moved = -1;
    set   = 0;
    if (r) begin
      for (int p = 0; p < NPE; p++) m_full[p] = 0;
      m_v = 0; m_d = 0; m_i = 0; m_ptr = 0; m_ovr = 0;
      return;
    end
    if (!m_v || rdy) begin
      m_v = 0;
      for (int k = 0; k < NPE; k++) begin
        if (moved < 0 && m_full[(m_ptr + k) % NPE]) moved = (m_ptr + k) % NPE;
      end
      if (moved >= 0) begin
        m_v = 1; m_d = m_slot[moved]; m_i = moved; m_ptr = (moved + 1) % NPE;
      end
    end
    for (int p = 0; p < NPE; p++) begin
      if (vld[p]) begin
        if (!m_full[p] || p == moved || !OVR_EN) begin
          m_slot[p] = data[p*16 +: 16];
          m_full[p] = 1;
        end else begin
          set = 1;
        end
      end else if (p == moved) begin
        m_full[p] = 0;
      end
    end
    if (OVR_EN) begin
      if (set)    m_ovr = 1;
      else if (c) m_ovr = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic [3:0] vld, input logic [63:0] data,
                       input logic rdy, input logic c);
    rst = r; i_valid = vld; i_data = data; dif.i_READY = rdy; clr = c;
    model_step(r, vld, data, rdy, c);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 4'b0, 64'b0, rdy, 1'b0);
  endtask

  task automatic mcheck(input string tag);
    chk({tag, "_valid"}, 32'(dif.o_VALID), 32'(m_v));
    chk({tag, "_busy"}, 32'(busy), 32'(m_v || m_full[0] || m_full[1] || m_full[2] || m_full[3]));
    chk({tag, "_ovr"}, 32'(ovr), 32'(m_ovr));
    if (m_v) begin
      chk({tag, "_data"}, 32'(dif.o_DATA), 32'(m_d));
      chk({tag, "_index"}, 32'(dif.o_INDEX), 32'(m_i));
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [63:0] data;
    logic        rdy;
    logic        ev;
    logic [15:0] ed;
    logic [1:0]  ei;
    logic        eb;
    logic        cd;
  } vec_t;

  vec_t tbl [11];
  logic [63:0] burst;
  logic [63:0] word;

  initial begin
    rst = 1'b1; i_valid = '0; i_data = '0; clr = 1'b0; dif.i_READY = 1'b0;
    burst = {16'h0A03, 16'h0A02, 16'h0A01, 16'h0A00};
    word  = '0;
    word[pe_index(0, 1, 2)*16 +: 16] = 16'h1234;
    @(posedge clk);
    #1;

    //            rst   vld      data    rdy  ev    ed        ei  eb  cd
    tbl[0]  = '{1'b1, 4'b0000, 64'b0,  1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 4'b0100, word,   1'b1, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 4'b0000, 64'b0,  1'b1, 1'b1, 16'h1234, 2'd2, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 4'b0000, 64'b0,  1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 4'b0000, 64'b0,  1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 4'b1111, burst,  1'b1, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'b0000, 64'b0,  1'b1, 1'b1, 16'h0A00, 2'd0, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 4'b0000, 64'b0,  1'b1, 1'b1, 16'h0A01, 2'd1, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 4'b0000, 64'b0,  1'b1, 1'b1, 16'h0A02, 2'd2, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 4'b0000, 64'b0,  1'b1, 1'b1, 16'h0A03, 2'd3, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 4'b0000, 64'b0,  1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0};

    for (int k = 0; k < 11; k++) begin
      cycle(tbl[k].rst, tbl[k].vld, tbl[k].data, tbl[k].rdy, 1'b0);
      chk($sformatf("tbl%0d_valid", k), 32'(dif.o_VALID), 32'(tbl[k].ev));
      chk($sformatf("tbl%0d_busy", k), 32'(busy), 32'(tbl[k].eb));
      chk($sformatf("tbl%0d_ovr", k), 32'(ovr), 32'd0);
      if (tbl[k].cd) begin
        chk($sformatf("tbl%0d_data", k), 32'(dif.o_DATA), 32'(tbl[k].ed));
        chk($sformatf("tbl%0d_index", k), 32'(dif.o_INDEX), 32'(tbl[k].ei));
      end
    end

    // Backpressure: first beat held for 5 stalled cycles, then the rest drain.
    cycle(1'b1, 4'b0, 64'b0, 1'b0, 1'b0);
    cycle(1'b0, 4'b1111, burst, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      idle(1'b0);
      chk("bp_hold_valid", 32'(dif.o_VALID), 32'd1);
      chk("bp_hold_data", 32'(dif.o_DATA), 32'h0A00);
      chk("bp_hold_index", 32'(dif.o_INDEX), 32'd0);
    end
    for (int k = 1; k < 4; k++) begin
      idle(1'b1);
      chk("bp_beat_valid", 32'(dif.o_VALID), 32'd1);
      chk("bp_beat_index", 32'(dif.o_INDEX), 32'(k));
      chk("bp_beat_data", 32'(dif.o_DATA), 32'h0A00 + 32'(k));
    end
    idle(1'b1);
    chk("bp_end_valid", 32'(dif.o_VALID), 32'd0);

    // Overrun: PE0 occupies the stalled output, PE1 is hit twice.
    cycle(1'b1, 4'b0, 64'b0, 1'b0, 1'b0);
    cycle(1'b0, 4'b0011, {32'b0, 16'h0011, 16'h00AA}, 1'b0, 1'b0);
    idle(1'b0);
    chk("ovr_first_index", 32'(dif.o_INDEX), 32'd0);
    cycle(1'b0, 4'b0010, {32'b0, 16'h0022, 16'h0000}, 1'b0, 1'b0);
    chk("ovr_set", 32'(ovr), OVR_EN ? 32'd1 : 32'd0);
    idle(1'b1);
    chk("ovr_drain_index", 32'(dif.o_INDEX), 32'd1);
    chk("ovr_drain_data", 32'(dif.o_DATA), OVR_EN ? 32'h0011 : 32'h0022);
    cycle(1'b0, 4'b0, 64'b0, 1'b1, 1'b1);
    chk("ovr_clear", 32'(ovr), 32'd0);

    // Same-slot refill: PE3 captured while its slot moves out.
    cycle(1'b1, 4'b0, 64'b0, 1'b0, 1'b0);
    cycle(1'b0, 4'b1000, {16'h3333, 48'b0}, 1'b1, 1'b0);
    cycle(1'b0, 4'b1000, {16'h0F0F, 48'b0}, 1'b1, 1'b0);
    chk("refill_first_data", 32'(dif.o_DATA), 32'h3333);
    chk("refill_ovr", 32'(ovr), 32'd0);
    idle(1'b1);
    chk("refill_second_valid", 32'(dif.o_VALID), 32'd1);
    chk("refill_second_index", 32'(dif.o_INDEX), 32'd3);
    chk("refill_second_data", 32'(dif.o_DATA), 32'h0F0F);

    // Reset mid-drain: after two beats, reset discards the rest.
    cycle(1'b1, 4'b0, 64'b0, 1'b0, 1'b0);
    cycle(1'b0, 4'b1111, burst, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("rstmid_beat1_index", 32'(dif.o_INDEX), 32'd1);
    cycle(1'b1, 4'b0, 64'b0, 1'b1, 1'b0);
    chk("rstmid_valid", 32'(dif.o_VALID), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      chk("rstmid_quiet", 32'(dif.o_VALID), 32'd0);
    end

    // Randomized traffic against the reference model.
    cycle(1'b1, 4'b0, 64'b0, 1'b0, 1'b0);
    mcheck("rnd_reset");
    for (int n = 0; n < 3000; n++) begin
      logic [3:0]  v;
      logic [63:0] d;
      for (int p = 0; p < NPE; p++) v[p] = ($urandom_range(0, 3) == 0);
      d = {$urandom, $urandom};
      cycle($urandom_range(0, 499) == 0, v, d, $urandom_range(0, 9) < 7,
            $urandom_range(0, 15) == 0);
      mcheck("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Result collector on the output side of the systolic array core. Captures the per-PE accumulator results and their valid strobes, holds each result in a per-PE slot, and drains them one per beat onto a single valid/ready stream tagged with the PE index. It absorbs bursts where many PEs finish in the same cycle and reports lost results.

## Interface
- DBITS, 8, operand width; each result is 2*DBITS bits
- ROWS, 2, PE rows of the array
- COLS, 2, PE columns of the array
- NPE = ROWS*COLS (derived); IDXW = max(1, clog2(NPE)) (derived)

- i_CLK  in  1  clock; all logic on rising edge
- i_RST  in  1  synchronous, active-high reset
- i_DATA  in  NPE*2*DBITS  array results, PE p at bits [(p+1)*2*DBITS-1 : p*2*DBITS], p = col*ROWS + row
- i_VALID  in  NPE  per-PE result strobe, 1-cycle pulse per result
- o_DATA  out  2*DBITS  drained result
- o_INDEX  out  IDXW  PE index p of o_DATA
- o_VALID  out  1  output beat valid
- i_READY  in  1  downstream accept
- o_BUSY  out  1  any slot full or o_VALID high
- o_OVERRUN  out  1  sticky: a result was lost
- i_CLR_OVR  in  1  clears o_OVERRUN

## Operation
- Per PE p: slot register (2*DBITS) plus full flag.
- Capture: i_VALID[p] && slot p empty → slot loads i_DATA[p], full set.
- Capture into slot p in the same cycle slot p is moved to the output register: accepted, slot stays full with the new value, no overrun.
- Output register (o_DATA, o_INDEX, o_VALID) loads when empty (o_VALID=0) or handshake this cycle (o_VALID && i_READY).
- Selection: round-robin over full slots, starting at pointer; pointer := selected index + 1, wrapping NPE-1 → 0.
- Moved slot clears full on the same edge the output register loads.
- Output held stable while o_VALID && !i_READY.
- Two-state output FSM: EMPTY (o_VALID=0) → FULL on load; FULL → EMPTY on handshake with no full slot; FULL → FULL on handshake with a full slot (back-to-back).
- o_OVERRUN sets when i_VALID[p] while slot p is full and not moving this cycle. i_CLR_OVR clears it; a simultaneous set wins.
- Reset: all full flags 0, pointer 0, o_VALID 0, o_DATA 0, o_INDEX 0, o_OVERRUN 0, o_BUSY 0. A reset mid-drain discards all held results.

## Timing
- Capture on edge ending cycle t; o_VALID visible at t+2 if the output register is free.
- Sustained throughput: one result per cycle with i_READY held high.
- An N-PE simultaneous burst drains in N consecutive beats, in round-robin order from the pointer.
- o_BUSY is combinational from the full flags and o_VALID.

## Configuration
- SYSTOLIC_DRAIN_OVR_EN defined: overrun detection as above. The new result is dropped and the held value is kept.
- Not defined: i_VALID on a full slot overwrites the held value silently. o_OVERRUN is tied 0 and i_CLR_OVR is ignored. Ports remain.

## Structure
- Shared package systolic_pkg: result width function (2*DBITS), PE index mapping function (col*ROWS+row), IDXW computation.
- One sub-module: systolic_rr_pick. It is combinational, takes an NPE-bit full vector and a pointer, and returns the found flag and the selected index.

## Test plan
All scenarios use DBITS=8, ROWS=COLS=2.
- Single result: i_VALID=4'b0100, PE2 data 16'h1234, i_READY=1 → one beat at t+2 with o_DATA=16'h1234, o_INDEX=2; o_BUSY falls afterwards.
- Full burst: i_VALID=4'b1111 with data 16'h0A00+p, pointer 0, i_READY=1 → four consecutive beats, indices 0,1,2,3.
- Backpressure: same burst with i_READY=0 for 5 cycles → o_DATA=16'h0A00, o_INDEX=0 held stable throughout; then 4 beats once ready.
- Overrun (macro on): PE1 pulses 16'h0011, then 16'h0022 while stalled → o_OVERRUN=1, drained value 16'h0011; i_CLR_OVR pulse → 0. Macro off: drained value 16'h0022, o_OVERRUN stays 0.
- Same-slot refill: PE3 slot moving to output while i_VALID[3] with 16'h0F0F → no overrun; a second PE3 beat carries 16'h0F0F.
- Reset mid-drain: i_RST during the burst after 2 beats → next cycle o_VALID=0, o_BUSY=0; no further beats.
